rr_dec_arbiter4: RTL

//  Round-robin arbiter sharing one 2-to-4 one-hot select resource among four requesters.

---
 rtl/rr_dec_arbiter4_if.sv | 25 ++
 rtl/rr_dec_arbiter4.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rr_dec_arbiter4_if.sv
// Request/grant bundle between requesting agents and the round-robin arbiter.
// The master side drives enable and requests; the arbiter drives grants.
interface rr_dec_arbiter4_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid
    );
endinterface

// File: rtl/rr_dec_arbiter4.sv
// Four-way round-robin arbiter with bounded tenure.
// Issues a registered grant index plus its one-hot dec24 decode.
module rr_dec_arbiter4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_dec_arbiter4_if.slave   bus
);

    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HMAX = CW'(HOLD_MAX);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    id_q, id_d;
    logic [1:0]    last_q, last_d;
    logic          valid_q, valid_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [2:0]    idle_win;
    logic [2:0]    oth_win;
    logic [3:0]    oth_req;

    function automatic logic [3:0] dec24(input logic [1:0] id);
        dec24 = 4'b0001 << id;
    endfunction

    // Returns {found, id}: first set bit scanning cyclically from start.
    function automatic logic [2:0] scan(
        input logic [3:0] r,
        input logic [1:0] start
    );
        logic [1:0] idx;
        logic       found;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        scan = {found, win};
    endfunction

    assign oth_req  = bus.req & ~dec24(id_q);
    assign idle_win = scan(bus.req, last_q + 2'd1);
    assign oth_win  = scan(oth_req, id_q + 2'd1);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        gnt_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.en && |bus.req) begin
                    state_d = GRANT;
                    id_d    = idle_win[1:0];
                    last_d  = idle_win[1:0];
                    valid_d = 1'b1;
                    hold_d  = CW'(1);
                end else begin
                    id_d    = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    id_d    = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end else if (!bus.req[id_q]) begin
                    if (oth_win[2]) begin
                        id_d   = oth_win[1:0];
                        last_d = oth_win[1:0];
                        hold_d = CW'(1);
                    end else begin
                        state_d = IDLE;
                        id_d    = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HMAX && oth_win[2]) begin
                    // Tenure exhausted with others waiting: rotate away.
                    id_d   = oth_win[1:0];
                    last_d = oth_win[1:0];
                    hold_d = CW'(1);
                end else if (hold_q != HMAX) begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase

        if (valid_d) begin
            gnt_d = dec24(id_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            last_q  <= 2'd3;
            valid_q <= 1'b0;
            gnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;

endmodule
